comma_aligner: RTL

COMMA_ALIGNER -- requirements
Module: comma_aligner

---
 rtl/comma_aligner.sv | 130 +++++++++++++
 1 files changed

// File: rtl/comma_aligner.sv
// comma_aligner: recovers 10-bit 8b/10b symbol boundaries from a serial line
// by hunting for K28.5 commas, confirming the phase over LOCK_COUNT aligned
// commas and dropping lock after LOSS_COUNT consecutive misaligned commas.
module comma_aligner #(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       Sin,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       is_comma,
  output logic       locked
);

  localparam int unsigned GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int unsigned MW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_MAX = MW'(LOSS_COUNT);

  localparam logic [9:0] COMMA_NEG = 10'b0011111010;
  localparam logic [9:0] COMMA_POS = 10'b1100000101;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t        state, state_n;
  logic [9:0]    sr;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0] good_cnt, good_cnt_n;
  logic [MW-1:0] miss_cnt, miss_cnt_n;
  logic          match, boundary;
  logic          emit, emit_comma;

  assign match    = (sr == COMMA_NEG) || (sr == COMMA_POS);
  assign boundary = (bit_cnt == 4'd9);

  // Serial shift register; sr[9] is the oldest bit.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= {sr[8:0], Sin};
  end

  // Next-state, counter and word-emission decisions.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = boundary ? 4'd0 : bit_cnt + 4'd1;
    good_cnt_n = good_cnt;
    miss_cnt_n = miss_cnt;
    emit       = 1'b0;
    emit_comma = 1'b0;
    case (state)
      HUNT: begin
        if (match) begin
          bit_cnt_n  = 4'd0;
          good_cnt_n = GW'(1);
          state_n    = (GW'(1) >= GOOD_MAX) ? LOCKED : CHECK;
          miss_cnt_n = '0;
          emit       = 1'b1;
          emit_comma = 1'b1;
        end
      end
      CHECK: begin
        if (match && boundary) begin
          good_cnt_n = good_cnt + GW'(1);
          emit       = 1'b1;
          emit_comma = 1'b1;
          if (good_cnt + GW'(1) >= GOOD_MAX) begin
            state_n    = LOCKED;
            miss_cnt_n = '0;
          end
        end else if (match) begin
          // Misaligned comma: adopt its phase and restart confirmation.
          bit_cnt_n  = 4'd0;
          good_cnt_n = GW'(1);
          emit       = 1'b1;
          emit_comma = 1'b1;
        end else if (boundary) begin
          emit = 1'b1;
        end
      end
      LOCKED: begin
        if (boundary) begin
          emit       = 1'b1;
          emit_comma = match;
          if (match) miss_cnt_n = '0;
        end else if (match) begin
          if (miss_cnt + MW'(1) >= MISS_MAX) begin
            state_n    = HUNT;
            good_cnt_n = '0;
            miss_cnt_n = '0;
          end else begin
            miss_cnt_n = miss_cnt + MW'(1);
          end
        end
      end
      default: begin
        state_n    = HUNT;
        good_cnt_n = '0;
        miss_cnt_n = '0;
      end
    endcase
  end

  // Register FSM state, counters and the aligned-word outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      is_comma   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      good_cnt   <= good_cnt_n;
      miss_cnt   <= miss_cnt_n;
      word_valid <= emit;
      if (emit) begin
        word     <= sr;
        is_comma <= emit_comma;
      end
      locked     <= (state_n == LOCKED);
    end
  end

endmodule
